// File: rtl/sum_job_scheduler_pkg.sv
// Shared types and defaults for the sum job scheduler: FSM state encodings,
// requester index type and the default datapath widths.
package sum_sched_pkg;

    localparam int DEF_NUM_W          = 6;
    localparam int DEF_ACC_W          = 11;
    localparam int DEF_TIMEOUT_CYCLES = 1023;

    typedef logic [1:0] sched_state_t;

    localparam sched_state_t ST_IDLE  = 2'd0;
    localparam sched_state_t ST_LOAD  = 2'd1;
    localparam sched_state_t ST_RUN   = 2'd2;
    localparam sched_state_t ST_STORE = 2'd3;

    // Requester 0 or 1
    typedef logic req_idx_t;

    function automatic logic [1:0] idx_to_onehot(input req_idx_t idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/sum_job_scheduler_rr_arbiter2.sv
// Two-way round-robin arbiter: on a tie the requester that was not served
// last wins. Purely combinational; grant is one-hot or zero.
module rr_arbiter2
    import sum_sched_pkg::*;
(
    input  logic [1:0] req,
    input  req_idx_t   last,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = idx_to_onehot(~last);
            default: gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/sum_job_scheduler.sv
// Shares one running-sum engine between two requesters: arbitrate, latch the
// target, sequence clear/run/store. Optional RUN timeout: SUM_SCHED_TIMEOUT_EN.
module sum_job_scheduler
    import sum_sched_pkg::*;
#(
    parameter int NUM_W          = DEF_NUM_W,
    parameter int ACC_W          = DEF_ACC_W,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       req,
    input  logic [NUM_W-1:0] num0,
    input  logic [NUM_W-1:0] num1,
    output logic [1:0]       grant,
    output logic [1:0]       done,
    output logic [ACC_W-1:0] result0,
    output logic [ACC_W-1:0] result1,
    output logic             eng_clear,
    output logic             eng_en,
    output logic [NUM_W-1:0] eng_target,
    input  logic             eng_max_reached,
    input  logic [ACC_W-1:0] eng_accum,
    output logic [1:0]       status_led,
    output logic [1:0]       err
);

    sched_state_t     state_reg;
    sched_state_t     state_next;
    req_idx_t         g_reg;
    req_idx_t         ptr_reg;
    req_idx_t         win_idx;
    logic [NUM_W-1:0] target_reg;
    logic             stored_reg;
    logic [1:0]       arb_gnt;
    logic             accept;
    logic             busy;
    logic             in_store;
    logic             timeout_hit;
    logic [ACC_W-1:0] store_value;

    rr_arbiter2 u_arb (
        .req  (req),
        .last (ptr_reg),
        .gnt  (arb_gnt)
    );

    assign win_idx     = arb_gnt[1] & ~arb_gnt[0];
    assign accept      = (state_reg == ST_IDLE) && (|req);
    assign busy        = (state_reg != ST_IDLE);
    assign in_store    = (state_reg == ST_STORE);
    // A zero target never runs the engine, so its accumulator is not trusted
    assign store_value = (target_reg == '0) ? '0 : eng_accum;

`ifdef SUM_SCHED_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] run_cnt_reg;
    logic [1:0]       err_reg;

    assign timeout_hit = (state_reg == ST_RUN) && !eng_max_reached
                         && (run_cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_cnt_reg <= '0;
            err_reg     <= 2'b00;
        end else begin
            run_cnt_reg <= (state_reg == ST_RUN) ? run_cnt_reg + 1'b1 : '0;
            err_reg     <= timeout_hit ? idx_to_onehot(g_reg) : 2'b00;
        end
    end

    assign err = err_reg;
`else
    assign timeout_hit = (TIMEOUT_CYCLES < 0);
    assign err         = 2'b00;
`endif

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:  if (|req) state_next = ST_LOAD;
            ST_LOAD:  state_next = (target_reg == '0) ? ST_STORE : ST_RUN;
            ST_RUN: begin
                if (eng_max_reached)  state_next = ST_STORE;
                else if (timeout_hit) state_next = ST_IDLE;
            end
            ST_STORE: state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Pointer resets to 1 so requester 0 wins the first-ever tie
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= ST_IDLE;
            g_reg      <= 1'b0;
            ptr_reg    <= 1'b1;
            target_reg <= '0;
            stored_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                g_reg      <= win_idx;
                target_reg <= win_idx ? num1 : num0;
            end
            if (in_store || timeout_hit)
                ptr_reg <= g_reg;
            if (in_store)
                stored_reg <= 1'b1;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_req
            logic [ACC_W-1:0] result_reg;
            logic             is_mine;

            assign is_mine = (g_reg == req_idx_t'(gi));

            always_ff @(posedge clk or posedge rst) begin
                if (rst)
                    result_reg <= '0;
                else if (in_store && is_mine)
                    result_reg <= store_value;
            end

            assign grant[gi] = busy && is_mine;
            assign done[gi]  = in_store && is_mine;
        end
    endgenerate

    assign result0    = g_req[0].result_reg;
    assign result1    = g_req[1].result_reg;
    assign eng_clear  = (state_reg == ST_LOAD);
    assign eng_en     = (state_reg == ST_RUN);
    assign eng_target = target_reg;
    assign status_led = {stored_reg, (state_reg == ST_RUN)};

endmodule

// File: tb/tb_sum_job_scheduler.sv
// Self-checking bench for sum_job_scheduler with a behavioural accumulator
// engine; honours SUM_SCHED_TIMEOUT_EN when the design is built with it.
module tb_sum_job_scheduler;

`ifdef SUM_SCHED_TIMEOUT_EN
    localparam int         TO_CYC = 16;
    localparam logic [5:0] BIG_N  = 6'd15;
`else
    localparam int         TO_CYC = 1023;
    localparam logic [5:0] BIG_N  = 6'd63;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [1:0]  req = 2'b00;
    logic [5:0]  num0 = '0;
    logic [5:0]  num1 = '0;
    logic [1:0]  grant;
    logic [1:0]  done;
    logic [10:0] result0;
    logic [10:0] result1;
    logic        eng_clear;
    logic        eng_en;
    logic [5:0]  eng_target;
    logic        eng_max_reached;
    logic [10:0] eng_accum = '0;
    logic [1:0]  status_led;
    logic [1:0]  err;

    logic [6:0]  eng_cnt = '0;
    logic        eng_stall = 1'b0;

    int checks = 0;
    int errors = 0;

    // model state: last served requester and each requester's last result
    logic        model_last;
    logic [10:0] model_res [2];

    typedef struct {
        logic [1:0]  r;
        logic [5:0]  n0;
        logic [5:0]  n1;
        logic [1:0]  exp_done;
        logic [10:0] exp_res;
    } vec_t;
    vec_t tbl [8];

    sum_job_scheduler #(
        .NUM_W          (6),
        .ACC_W          (11),
        .TIMEOUT_CYCLES (TO_CYC)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .req             (req),
        .num0            (num0),
        .num1            (num1),
        .grant           (grant),
        .done            (done),
        .result0         (result0),
        .result1         (result1),
        .eng_clear       (eng_clear),
        .eng_en          (eng_en),
        .eng_target      (eng_target),
        .eng_max_reached (eng_max_reached),
        .eng_accum       (eng_accum),
        .status_led      (status_led),
        .err             (err)
    );

    always #5 clk = ~clk;

    // Behavioural accumulator engine: one step adds the next integer
    always @(posedge clk) begin
        if (eng_clear) begin
            eng_cnt   <= '0;
            eng_accum <= '0;
        end else if (eng_en && !eng_max_reached) begin
            eng_cnt   <= eng_cnt + 7'd1;
            eng_accum <= eng_accum + 11'(eng_cnt) + 11'd1;
        end
    end
    assign eng_max_reached = !eng_stall && (eng_cnt == {1'b0, eng_target});

    function automatic logic [10:0] tri_sum(input logic [5:0] n);
        int v;
        v = int'(n) * (int'(n) + 1) / 2;
        return 11'(v);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = 2'b00;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_last   = 1'b1;
        model_res[0] = '0;
        model_res[1] = '0;
    endtask

    task automatic wait_done(input int budget, output logic [1:0] d, output int cyc);
        d = 2'b00;
        cyc = 0;
        while (d == 2'b00 && cyc < budget) begin
            @(negedge clk);
            cyc++;
            d = done;
        end
        checks++;
        if (d == 2'b00) begin
            errors++;
            $display("FAIL done_wait actual=none required=pulse within %0d cycles", budget);
        end
    endtask

    task automatic observe_job(input int budget, output int n_clr, output int n_en,
                               output int n_led0, output int cyc,
                               output logic [1:0] g_seen, output logic [1:0] d);
        n_clr = 0; n_en = 0; n_led0 = 0; cyc = 0; g_seen = 2'b00; d = 2'b00;
        while (d == 2'b00 && cyc < budget) begin
            @(negedge clk);
            cyc++;
            n_clr  += int'(eng_clear);
            n_en   += int'(eng_en);
            n_led0 += int'(status_led[0]);
            g_seen |= grant;
            d = done;
        end
        checks++;
        if (d == 2'b00) begin
            errors++;
            $display("FAIL job_wait actual=none required=done within %0d cycles", budget);
        end
    endtask

    // One complete job from IDLE; optionally perturbs num/req once target is latched
    task automatic run_job(input string tag, input logic [1:0] r, input logic [5:0] n0,
                           input logic [5:0] n1, input logic [1:0] exp_d,
                           input logic [10:0] exp_res, input bit mutate);
        logic [1:0] d;
        int         cyc;
        logic       w;
        req = r; num0 = n0; num1 = n1;
        @(negedge clk);
        if (mutate) begin
            num0 = 6'($urandom_range(0, 63));
            num1 = 6'($urandom_range(0, 63));
            if ($urandom_range(0, 1) == 1) req = 2'b00;
        end
        wait_done(200, d, cyc);
        check({tag, "_done"}, 32'(d), 32'(exp_d));
        req = 2'b00;
        @(negedge clk);
        w = exp_d[1];
        model_res[w] = exp_res;
        model_last   = w;
        check({tag, "_result0"}, 32'(result0), 32'(model_res[0]));
        check({tag, "_result1"}, 32'(result1), 32'(model_res[1]));
        $display("job %s req=%b num0=%0d num1=%0d done=%b result0=%0d result1=%0d",
                 tag, r, n0, n1, d, result0, result1);
    endtask

    initial begin
        int         n_clr, n_en, n_led0, cyc;
        logic [1:0] g_seen, d;
        logic [1:0] err_or;
        logic [1:0] exp_order [4];

        tbl[0] = '{2'b01, 6'd5,  6'd9,  2'b01, 11'd15};
        tbl[1] = '{2'b11, 6'd3,  6'd4,  2'b10, 11'd10};
        tbl[2] = '{2'b11, 6'd3,  6'd4,  2'b01, 11'd6};
        tbl[3] = '{2'b10, 6'd2,  6'd0,  2'b10, 11'd0};
        tbl[4] = '{2'b11, BIG_N, 6'd1,  2'b01, tri_sum(BIG_N)};
        tbl[5] = '{2'b11, 6'd7,  6'd1,  2'b10, 11'd1};
        tbl[6] = '{2'b10, 6'd0,  BIG_N, 2'b10, tri_sum(BIG_N)};
        tbl[7] = '{2'b11, 6'd0,  6'd5,  2'b01, 11'd0};

        // Reset state
        do_reset();
        check("rst_grant", 32'(grant), 0);
        check("rst_done", 32'(done), 0);
        check("rst_results", 32'({result0, result1}), 0);
        check("rst_engine", 32'({eng_clear, eng_en, eng_target}), 0);
        check("rst_led_err", 32'({status_led, err}), 0);

        // Single job, target 5
        req = 2'b01; num0 = 6'd5; num1 = 6'd0;
        observe_job(100, n_clr, n_en, n_led0, cyc, g_seen, d);
        check("single_grant", 32'(g_seen), 32'(2'b01));
        check("single_clear_cycles", n_clr, 1);
        check("single_en_cycles", n_en, 6);
        check("single_led0_cycles", n_led0, 6);
        check("single_done", 32'(d), 32'(2'b01));
        req = 2'b00;
        @(negedge clk);
        check("single_result0", 32'(result0), 15);
        check("single_result1", 32'(result1), 0);
        check("single_led", 32'(status_led), 32'(2'b10));
        check("single_done_cleared", 32'(done), 0);
        $display("job single req=01 num0=5 done=%b result0=%0d", d, result0);
        model_res[0] = 11'd15; model_last = 1'b0;

        // Zero target: LOAD then STORE, engine never enabled
        req = 2'b10; num1 = 6'd0;
        observe_job(20, n_clr, n_en, n_led0, cyc, g_seen, d);
        check("zero_latency", cyc, 2);
        check("zero_en_cycles", n_en, 0);
        check("zero_done", 32'(d), 32'(2'b10));
        req = 2'b00;
        @(negedge clk);
        check("zero_result1", 32'(result1), 0);
        check("zero_result0_kept", 32'(result0), 15);
        $display("job zero req=10 num1=0 done=%b result1=%0d", d, result1);
        model_last = 1'b1;

        // Target and req change mid-job are ignored
        req = 2'b01; num0 = 6'd7;
        @(negedge clk);
        @(negedge clk);
        check("mid_in_run", 32'(eng_en), 1);
        num0 = 6'd2; req = 2'b00;
        observe_job(100, n_clr, n_en, n_led0, cyc, g_seen, d);
        check("mid_target_held", 32'(eng_target), 7);
        check("mid_done", 32'(d), 32'(2'b01));
        @(negedge clk);
        check("mid_result0", 32'(result0), 28);
        $display("job midchange req=01 num0=7->2 done=%b result0=%0d", d, result0);
        model_res[0] = 11'd28; model_last = 1'b0;

        // Asynchronous reset while RUN
        req = 2'b01; num0 = 6'd10;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        check("rstrun_in_run", 32'(eng_en), 1);
        #2 rst = 1'b1;
        #1;
        check("rstrun_engine", 32'({eng_en, eng_clear, eng_target}), 0);
        check("rstrun_grant_done", 32'({grant, done}), 0);
        check("rstrun_results", 32'({result0, result1}), 0);
        check("rstrun_led", 32'(status_led), 0);
        @(negedge clk);
        check("rstrun_no_done", 32'(done), 0);
        rst = 1'b0; req = 2'b00;
        model_last = 1'b1; model_res[0] = '0; model_res[1] = '0;
        run_job("after_rst", 2'b01, 6'd4, 6'd0, 2'b01, 11'd10, 1'b0);

        // Held tie: service alternates 0,1,0,1
        do_reset();
        exp_order[0] = 2'b01; exp_order[1] = 2'b10;
        exp_order[2] = 2'b01; exp_order[3] = 2'b10;
        req = 2'b11; num0 = 6'd3; num1 = 6'd4;
        for (int k = 0; k < 4; k++) begin
            wait_done(100, d, cyc);
            check($sformatf("tie_order%0d", k), 32'(d), 32'(exp_order[k]));
            $display("job tie%0d req=11 done=%b", k, d);
        end
        req = 2'b00;
        @(negedge clk);
        check("tie_result0", 32'(result0), 6);
        check("tie_result1", 32'(result1), 10);

        // Table-driven jobs from a fresh reset
        do_reset();
        for (int i = 0; i < 8; i++)
            run_job($sformatf("tbl%0d", i), tbl[i].r, tbl[i].n0, tbl[i].n1,
                    tbl[i].exp_done, tbl[i].exp_res, 1'b0);

        // Randomized jobs against the round-robin / triangular-number model
        for (int i = 0; i < 40; i++) begin
            logic [1:0] r;
            logic [5:0] n0, n1;
            logic       w;
            r  = 2'($urandom_range(1, 3));
            n0 = 6'($urandom_range(0, int'(BIG_N)));
            n1 = 6'($urandom_range(0, int'(BIG_N)));
            w  = (r == 2'b11) ? ~model_last : r[1];
            run_job($sformatf("rnd%0d", i), r, n0, n1, w ? 2'b10 : 2'b01,
                    tri_sum(w ? n1 : n0), bit'($urandom_range(0, 1)));
        end

        // Engine that never finishes
        do_reset();
        run_job("pre_stall", 2'b01, 6'd5, 6'd0, 2'b01, 11'd15, 1'b0);
        eng_stall = 1'b1;
        req = 2'b01; num0 = 6'd5;
`ifdef SUM_SCHED_TIMEOUT_EN
        n_en = 0; cyc = 0; d = 2'b00; err_or = 2'b00;
        while (err_or == 2'b00 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            n_en   += int'(eng_en);
            d      |= done;
            err_or |= err;
            if (eng_en) req = 2'b00;
        end
        check("to_err", 32'(err_or), 32'(2'b01));
        check("to_run_cycles", n_en, TO_CYC);
        check("to_no_done", 32'(d), 0);
        check("to_idle", 32'({grant, eng_en}), 0);
        @(negedge clk);
        check("to_err_pulse", 32'(err), 0);
        check("to_result0_kept", 32'(result0), 15);
        $display("job timeout req=01 err=%b run_cycles=%0d result0=%0d", err_or, n_en, result0);
`else
        err_or = 2'b00;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            err_or |= err;
        end
        check("stall_still_run", 32'(eng_en), 1);
        check("stall_no_err", 32'(err_or), 0);
        check("stall_result0_kept", 32'(result0), 15);
        $display("job stall req=01 eng_en=%b err=%b", eng_en, err_or);
`endif
        eng_stall = 1'b0;
        do_reset();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
